stack_alu_ctrl: RTL

STACK_ALU_CTRL -- requirements
Module: stack_alu_ctrl

---
 rtl/stack_alu_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/stack_alu_ctrl.sv
// stack_alu_ctrl: operand-stack controller that sequences an external
// combinational ALU. Stack ops finish in the accept cycle. Binary ops take
// two extra cycles: EXEC presents the operands, and WB writes the result back
// into the NOS slot.
// Optional feature: define STACK_ALU_CTRL_STICKY_ERR_EN to make the error
// flags latch until rst. By default they pulse for one cycle.
module stack_alu_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [3:0]                   cmd,
  input  logic [7:0]                   cmd_data,
  output logic [7:0]                   alu_a,
  output logic [7:0]                   alu_b,
  output logic [3:0]                   alu_op,
  input  logic [7:0]                   alu_out,
  output logic [7:0]                   tos,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         err_underflow,
  output logic                         err_overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] TWO     = CW'(2);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [3:0] CMD_PUSH = 4'd8;
  localparam logic [3:0] CMD_POP  = 4'd9;
  localparam logic [3:0] CMD_DUP  = 4'd10;
  localparam logic [3:0] CMD_SWAP = 4'd11;
  localparam logic [3:0] OP_NUL   = 4'd8;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      aluA_q, aluA_d;
  logic [7:0]      aluB_q, aluB_d;
  logic [3:0]      aluOp_q, aluOp_d;
  logic [7:0]      result_q, result_d;
  logic            errUnder_q, errUnder_d;
  logic            errOver_q, errOver_d;

  logic            wrEnA, wrEnB;
  logic [AW-1:0]   wrIdxA, wrIdxB;
  logic [7:0]      wrDataA, wrDataB;
  logic            underHit, overHit;

  logic [AW-1:0]   topIdx, nosIdx, pushIdx;
  logic [7:0]      topVal, nosVal;

  // Slot indices derived from the occupancy; only dereferenced when the
  // occupancy makes them valid
  assign topIdx  = AW'(count_q - ONE);
  assign nosIdx  = AW'(count_q - TWO);
  assign pushIdx = AW'(count_q);
  assign topVal  = (count_q == '0) ? 8'h00 : mem_q[topIdx];
  assign nosVal  = mem_q[nosIdx];

  assign cmd_ready     = (state_q == IDLE);
  assign alu_a         = aluA_q;
  assign alu_b         = aluB_q;
  assign alu_op        = aluOp_q;
  assign tos           = topVal;
  assign count         = count_q;
  assign empty         = (count_q == '0);
  assign full          = (count_q == DEPTH_C);
  assign err_underflow = errUnder_q;
  assign err_overflow  = errOver_q;

  // Next-state logic: decode accepted commands, sequence EXEC/WB, and plan up to two stack writes
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    aluA_d   = 8'h00;
    aluB_d   = 8'h00;
    aluOp_d  = OP_NUL;
    result_d = result_q;
    wrEnA    = 1'b0;
    wrEnB    = 1'b0;
    wrIdxA   = '0;
    wrIdxB   = '0;
    wrDataA  = 8'h00;
    wrDataB  = 8'h00;
    underHit = 1'b0;
    overHit  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_PUSH: begin
              if (count_q == DEPTH_C) begin
                overHit = 1'b1;
              end else begin
                wrEnA   = 1'b1;
                wrIdxA  = pushIdx;
                wrDataA = cmd_data;
                count_d = count_q + ONE;
              end
            end
            CMD_POP: begin
              if (count_q == '0) begin
                underHit = 1'b1;
              end else begin
                count_d = count_q - ONE;
              end
            end
            CMD_DUP: begin
              if (count_q == '0) begin
                underHit = 1'b1;
              end else if (count_q == DEPTH_C) begin
                overHit = 1'b1;
              end else begin
                wrEnA   = 1'b1;
                wrIdxA  = pushIdx;
                wrDataA = topVal;
                count_d = count_q + ONE;
              end
            end
            CMD_SWAP: begin
              if (count_q < TWO) begin
                underHit = 1'b1;
              end else begin
                wrEnA   = 1'b1;
                wrIdxA  = topIdx;
                wrDataA = nosVal;
                wrEnB   = 1'b1;
                wrIdxB  = nosIdx;
                wrDataB = topVal;
              end
            end
            default: begin
              if (!cmd[3]) begin
                if (count_q < TWO) begin
                  underHit = 1'b1;
                end else begin
                  state_d = EXEC;
                  aluA_d  = nosVal;
                  aluB_d  = topVal;
                  aluOp_d = cmd;
                end
              end
            end
          endcase
        end
      end
      EXEC: begin
        state_d  = WB;
        result_d = alu_out;
      end
      WB: begin
        wrEnA   = 1'b1;
        wrIdxA  = nosIdx;
        wrDataA = result_q;
        count_d = count_q - ONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef STACK_ALU_CTRL_STICKY_ERR_EN
    errUnder_d = errUnder_q | underHit;
    errOver_d  = errOver_q | overHit;
`else
    errUnder_d = underHit;
    errOver_d  = overHit;
`endif
  end

  // State register. Reset abandons any in-flight op, so WB cannot write after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      aluA_q     <= 8'h00;
      aluB_q     <= 8'h00;
      aluOp_q    <= OP_NUL;
      result_q   <= 8'h00;
      errUnder_q <= 1'b0;
      errOver_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      aluOp_q    <= aluOp_d;
      result_q   <= result_d;
      errUnder_q <= errUnder_d;
      errOver_q  <= errOver_d;
      if (wrEnA) mem_q[wrIdxA] <= wrDataA;
      if (wrEnB) mem_q[wrIdxB] <= wrDataB;
    end
  end

endmodule
